// File: rtl/fft_io_sequencer.sv
// Frame sequencer for the in-place radix-2 FFT: loads N samples bit-reversed into the
// shared RAM, hands the RAM to the address generator, then streams results in natural order.
module fft_io_sequencer #(
  parameter int N     = 8,
  parameter int LOG2N = 3,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [DW-1:0]    s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [DW-1:0]    m_data_o,
  output logic             m_last_o,
  output logic             fft_start_o,
  input  logic             fft_done_i,
  output logic             ram_sel_o,
  output logic             ram_wr_en_o,
  output logic [LOG2N-1:0] ram_wr_addr_o,
  output logic [DW-1:0]    ram_wr_data_o,
  output logic             ram_rd_en_o,
  output logic [LOG2N-1:0] ram_rd_addr_o,
  input  logic [DW-1:0]    ram_rd_data_i,
  output logic             busy_o,
  output logic [1:0]       state_o
);

  // Both streams use valid/ready: a beat transfers on a rising edge where valid and
  // ready are both high; a source holds valid and its data stable until that edge.

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    START   = 2'd1,
    COMPUTE = 2'd2,
    UNLOAD  = 2'd3
  } state_t;

  localparam logic [LOG2N-1:0] LAST_BIN = LOG2N'(N - 1);
  localparam logic [LOG2N:0]   N_CNT    = (LOG2N + 1)'(N);

  state_t           state_q, state_d;
  logic [LOG2N-1:0] in_cnt_q, in_cnt_d;
  logic [LOG2N:0]   rd_cnt_q, rd_cnt_d;
  logic [LOG2N-1:0] out_cnt_q, out_cnt_d;
  logic             s_ready_q, s_ready_d;
  logic             fft_start_q, fft_start_d;
  logic             ram_sel_q, ram_sel_d;
  logic             busy_q, busy_d;
  logic             wr_en_q, wr_en_d;
  logic [LOG2N-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic             inflight_q;

  logic [DW-1:0]    fifo_q [2];
  logic             fifo_wptr_q, fifo_rptr_q;
  logic [1:0]       fifo_cnt_q;

  logic             accept;
  logic             pop;
  logic             rd_issue;
  logic [2:0]       occ;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  assign accept = s_valid_i && s_ready_q && (state_q == LOAD);
  assign pop    = m_valid_o && m_ready_i;
  // Occupancy after this cycle's pop; a new read is allowed only if its data will fit.
  assign occ      = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue = (state_q == UNLOAD) && (rd_cnt_q < N_CNT) && (occ < 3'd2);

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_cnt_d   = out_cnt_q;
    fft_start_d = 1'b0;
    ram_sel_d   = ram_sel_q;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = bitrev(in_cnt_q);
          wr_data_d = s_data_i;
          in_cnt_d  = in_cnt_q + 1'b1;
          busy_d    = 1'b1;
          if (in_cnt_q == LAST_BIN) state_d = START;
        end
      end
      START: begin
        fft_start_d = 1'b1;
        ram_sel_d   = 1'b1;
        state_d     = COMPUTE;
      end
      COMPUTE: begin
        // The cycle carrying fft_start is not yet a compute cycle for done detection.
        if (fft_done_i && !fft_start_q) begin
          ram_sel_d = 1'b0;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = UNLOAD;
        end
      end
      UNLOAD: begin
        if (rd_issue) rd_cnt_d = rd_cnt_q + 1'b1;
        if (pop) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == LAST_BIN) begin
            state_d   = LOAD;
            in_cnt_d  = '0;
            rd_cnt_d  = '0;
            out_cnt_d = '0;
            busy_d    = 1'b0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    s_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD;
      in_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      s_ready_q   <= 1'b0;
      fft_start_q <= 1'b0;
      ram_sel_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_cnt_q   <= out_cnt_d;
      s_ready_q   <= s_ready_d;
      fft_start_q <= fft_start_d;
      ram_sel_q   <= ram_sel_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      inflight_q  <= rd_issue;
    end
  end

  // Two-entry output buffer; read data lands one cycle after the read was issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_q[fifo_wptr_q] <= ram_rd_data_i;
        fifo_wptr_q         <= ~fifo_wptr_q;
      end
      if (pop) fifo_rptr_q <= ~fifo_rptr_q;
      case ({inflight_q, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign s_ready_o     = s_ready_q;
  assign m_valid_o     = (fifo_cnt_q != 2'd0);
  assign m_data_o      = fifo_q[fifo_rptr_q];
  assign m_last_o      = m_valid_o && (out_cnt_q == LAST_BIN);
  assign fft_start_o   = fft_start_q;
  assign ram_sel_o     = ram_sel_q;
  assign ram_wr_en_o   = wr_en_q;
  assign ram_wr_addr_o = wr_addr_q;
  assign ram_wr_data_o = wr_data_q;
  assign ram_rd_en_o   = rd_issue;
  assign ram_rd_addr_o = rd_cnt_q[LOG2N-1:0];
  assign busy_o        = busy_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fft_io_sequencer.sv
// Bench for fft_io_sequencer: echo RAM model, output scoreboard and per-scenario tasks.
`timescale 1ns/1ps
module tb_fft_io_sequencer;
  localparam int N = 8;
  localparam int LOG2N = 3;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DW-1:0]    s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DW-1:0]    m_data;
  logic             m_last;
  logic             fft_start;
  logic             fft_done = 1'b0;
  logic             ram_sel;
  logic             ram_wr_en;
  logic [LOG2N-1:0] ram_wr_addr;
  logic [DW-1:0]    ram_wr_data;
  logic             ram_rd_en;
  logic [LOG2N-1:0] ram_rd_addr;
  logic [DW-1:0]    ram_rd_data = '0;
  logic             busy;
  logic [1:0]       state;

  always #5 clk = ~clk;

  fft_io_sequencer #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
    .fft_start_o(fft_start), .fft_done_i(fft_done), .ram_sel_o(ram_sel),
    .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data),
    .ram_rd_en_o(ram_rd_en), .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data),
    .busy_o(busy), .state_o(state)
  );

  // Butterfly RAM stand-in: the address generator never touches it, so results echo inputs.
  logic [DW-1:0] ram_mem [N];
  always @(posedge clk) begin
    if (ram_wr_en && !ram_sel) ram_mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0]    exp_q[$];
  logic [LOG2N-1:0] wr_addr_log[$];
  logic [DW-1:0]    wr_data_log[$];
  logic [DW-1:0]    exp_d;
  logic [DW-1:0]    stall_data;
  logic             stall_last;
  logic             stall_hold = 1'b0;
  logic             ram_sel_prev = 1'b0;
  logic             exp_last;
  logic             expect_quiet = 1'b0;
  logic             hold_s_valid = 1'b0;
  int out_idx = 0;
  int frames_done = 0;
  int outstanding = 0;
  int accept_cnt = 0;
  int start_cnt = 0;
  int last_accept_cyc = 0;
  int start_cyc = 0;
  int sel_fall_cyc = 0;
  int first_rd_cyc = -1;
  int first_mv_cyc = -1;
  int last_pop_cyc = 0;
  int done_cyc = 0;

  function automatic logic [2:0] brev3(input logic [2:0] a);
    return {a[0], a[1], a[2]};
  endfunction

  // Output scoreboard and per-cycle protocol observation.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      out_idx = 0;
      stall_hold = 1'b0;
      outstanding = 0;
      ram_sel_prev = 1'b0;
    end else begin
      if (ram_wr_en) begin
        wr_addr_log.push_back(ram_wr_addr);
        wr_data_log.push_back(ram_wr_data);
      end
      if (s_valid && s_ready) begin
        accept_cnt++;
        last_accept_cyc = cyc;
      end
      if (fft_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (ram_sel_prev && !ram_sel) sel_fall_cyc = cyc;
      ram_sel_prev = ram_sel;
      if (ram_rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
      if (expect_quiet) begin
        checks++;
        if (s_ready !== 1'b0 || ram_wr_en !== 1'b0) begin
          errors++;
          $display("FAIL quiet_outside_load: s_ready=%b wr_en=%b, required 0 and 0 (cycle %0d)", s_ready, ram_wr_en, cyc);
        end
      end
      if (stall_hold) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== stall_data || m_last !== stall_last) begin
          errors++;
          $display("FAIL stall_stable: valid=%b data=%h last=%b, required 1 %h %b", m_valid, m_data, m_last, stall_data, stall_last);
        end
      end
      stall_hold = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
      if (ram_rd_en) outstanding++;
      if (m_valid && m_ready) begin
        outstanding--;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_data: got unexpected bin %h, required no output", m_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (m_data !== exp_d) begin
            errors++;
            $display("FAIL out_data: bin %0d got %h, required %h", out_idx, m_data, exp_d);
          end
        end
        exp_last = (out_idx == N - 1);
        checks++;
        if (m_last !== exp_last) begin
          errors++;
          $display("FAIL out_last: bin %0d got m_last=%b, required %b", out_idx, m_last, exp_last);
        end
        if (out_idx == N - 1) begin
          out_idx = 0;
          frames_done++;
          last_pop_cyc = cyc;
        end else begin
          out_idx++;
        end
      end
      if (ram_rd_en || (m_valid && m_ready)) begin
        checks++;
        if (outstanding > 2) begin
          errors++;
          $display("FAIL outstanding: %0d reads buffered or in flight, required at most 2", outstanding);
        end
      end
    end
  end

  task automatic load_frame(input logic [31:0] base, input int gap);
    int n;
    for (int k = 0; k < N; k++) exp_q.push_back(base + ({29'd0, brev3(3'(k))} << 16));
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      s_valid = 1'b1;
      s_data = base + (32'(i) << 16);
      n = 0;
      while (s_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      checks++;
      if (n >= 100) begin
        errors++;
        $display("FAIL load_timeout: sample %0d not accepted, s_ready=%b required 1", i, s_ready);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic run_compute(input int delay);
    int n;
    int s0;
    s0 = start_cnt;
    n = 0;
    while (start_cnt == s0 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL start_timeout: fft_start pulses=%0d, required %0d", start_cnt - s0, 1);
    end
    repeat (delay - 1) begin @(posedge clk); #1; end
    checks++;
    if (ram_sel !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL compute_owner: ram_sel=%b busy=%b, required 1 1", ram_sel, busy);
    end
    first_rd_cyc = -1;
    first_mv_cyc = -1;
    fft_done = 1'b1;
    done_cyc = cyc;
    @(posedge clk); #1;
    fft_done = 1'b0;
  endtask

  task automatic unload(input int mode, input int spur_k);
    int k;
    int f0;
    f0 = frames_done;
    k = 0;
    while (frames_done == f0 && k < 300) begin
      if (spur_k >= 0 && k == spur_k + 2) begin
        checks++;
        if (state !== 2'd3 || ram_sel !== 1'b0 || fft_start !== 1'b0) begin
          errors++;
          $display("FAIL spurious_unload: state=%0d ram_sel=%b start=%b, required 3 0 0", state, ram_sel, fft_start);
        end
      end
      fft_done = (k == spur_k);
      if (hold_s_valid && out_idx >= 6) begin
        s_valid = 1'b0;
        hold_s_valid = 1'b0;
        expect_quiet = 1'b0;
      end
      m_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      @(posedge clk); #1;
      k++;
    end
    fft_done = 1'b0;
    m_ready = 1'b1;
    checks++;
    if (frames_done == f0) begin
      errors++;
      $display("FAIL unload_timeout: frames completed=%0d, required %0d", frames_done - f0, 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({s_ready, m_valid, m_last, fft_start, ram_sel, ram_wr_en, ram_rd_en, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: rdy/mv/last/start/sel/wr/rd/busy=%b, required 00000000",
               {s_ready, m_valid, m_last, fft_start, ram_sel, ram_wr_en, ram_rd_en, busy});
    end
    checks++;
    if (m_data !== '0 || ram_wr_data !== '0 || ram_wr_addr !== '0 || ram_rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_data: m_data=%h wr_data=%h wr_addr=%0d rd_addr=%0d, required all 0",
               m_data, ram_wr_data, ram_wr_addr, ram_rd_addr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: s_ready=%b m_valid=%b busy=%b state=%0d, required 1 0 0 0", s_ready, m_valid, busy, state);
    end
  endtask

  task automatic test_full_frame();
    logic [LOG2N-1:0] exp_addr [N];
    int st0;
    exp_addr = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    wr_addr_log.delete();
    wr_data_log.delete();
    st0 = start_cnt;
    m_ready = 1'b1;
    load_frame(32'h0, 0);
    run_compute(5);
    checks++;
    if (start_cyc !== last_accept_cyc + 2 || start_cnt - st0 !== 1) begin
      errors++;
      $display("FAIL start_timing: start at +%0d, %0d pulses, required +2 and 1 pulse", start_cyc - last_accept_cyc, start_cnt - st0);
    end
    checks++;
    if (wr_addr_log.size() != N) begin
      errors++;
      $display("FAIL write_count: got %0d writes, required %0d", wr_addr_log.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (wr_addr_log[i] !== exp_addr[i] || wr_data_log[i] !== (32'(i) << 16)) begin
          errors++;
          $display("FAIL write_%0d: addr=%0d data=%h, required addr=%0d data=%h", i, wr_addr_log[i], wr_data_log[i], exp_addr[i], 32'(i) << 16);
        end
      end
    end
    unload(0, -1);
    checks++;
    if (sel_fall_cyc !== done_cyc + 1 || first_rd_cyc !== done_cyc + 1) begin
      errors++;
      $display("FAIL done_response: ram_sel fall +%0d, first read +%0d, required +1 +1", sel_fall_cyc - done_cyc, first_rd_cyc - done_cyc);
    end
    checks++;
    if (first_mv_cyc !== done_cyc + 3 || last_pop_cyc !== first_mv_cyc + N - 1) begin
      errors++;
      $display("FAIL stream_timing: first m_valid +%0d, last bin +%0d, required +3 +%0d", first_mv_cyc - done_cyc, last_pop_cyc - done_cyc, N + 2);
    end
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: s_ready=%b busy=%b, required 1 0", s_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    load_frame(32'h0000_1234, 0);
    run_compute(3);
    unload(1, -1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: %0d bins not delivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_ignored_inputs();
    int a0;
    a0 = accept_cnt;
    wr_addr_log.delete();
    wr_data_log.delete();
    load_frame(32'h8000_0001, 2);
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data = 32'hDEAD_BEEF;
    hold_s_valid = 1'b1;
    expect_quiet = 1'b1;
    run_compute(6);
    unload(0, -1);
    s_valid = 1'b0;
    hold_s_valid = 1'b0;
    expect_quiet = 1'b0;
    checks++;
    if (accept_cnt - a0 != N || wr_addr_log.size() != N) begin
      errors++;
      $display("FAIL ignore_count: %0d accepts %0d writes, required %0d %0d", accept_cnt - a0, wr_addr_log.size(), N, N);
    end
  endtask

  task automatic test_spurious_done();
    @(posedge clk); #1;
    fft_done = 1'b1;
    @(posedge clk); #1;
    fft_done = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state !== 2'd0 || ram_sel !== 1'b0 || fft_start !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL spurious_load: state=%0d sel=%b start=%b rdy=%b busy=%b, required 0 0 0 1 0", state, ram_sel, fft_start, s_ready, busy);
    end
    load_frame(32'h0042_0007, 0);
    run_compute(4);
    unload(0, 3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL spurious_drain: %0d bins not delivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_unload();
    int k;
    m_ready = 1'b1;
    load_frame(32'h1111_0000, 0);
    run_compute(5);
    k = 0;
    while (out_idx < 4 && k < 50) begin @(posedge clk); #1; k++; end
    checks++;
    if (out_idx != 4) begin
      errors++;
      $display("FAIL mid_unload_reach: delivered %0d bins, required 4", out_idx);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({s_ready, m_valid, m_last, fft_start, ram_sel, ram_wr_en, ram_rd_en, busy} !== 8'h00) begin
      errors++;
      $display("FAIL midreset_ctrl: rdy/mv/last/start/sel/wr/rd/busy=%b, required 00000000",
               {s_ready, m_valid, m_last, fft_start, ram_sel, ram_wr_en, ram_rd_en, busy});
    end
    checks++;
    if (m_data !== '0 || ram_rd_addr !== '0 || state !== 2'd0) begin
      errors++;
      $display("FAIL midreset_data: m_data=%h rd_addr=%0d state=%0d, required 0 0 0", m_data, ram_rd_addr, state);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_release: s_ready=%b, required 1", s_ready);
    end
    load_frame(32'h2222_0000, 0);
    run_compute(5);
    unload(0, -1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_drain: %0d bins not delivered, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_ignored_inputs();
    test_spurious_done();
    test_reset_mid_unload();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
